ccff_stream_loader: RTL and testbench

- Upstream feeder for the configuration-chain (ccff) of logical tiles such as the IO tile.
- Accepts configuration bytes over a valid/ready stream and serialises them MSB-first onto `ccff_head`, one bit per `prog_clk` cycle.
- Drives a shift-enable to the chain's clock gate, so the chain advances only when a valid bit is presented.
- Sits between the PMU bitstream source (decrypt/authenticate path) and the head of the fabric ccff chain.

---
 rtl/ccff_stream_loader.sv | 153 +++++++++++++++
 tb/tb_ccff_stream_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_stream_loader.sv
// Serialises a byte stream MSB-first onto the head of a fabric ccff chain.
// Define CCFF_LOADER_CRC_EN to append a CRC-8 check byte after the chain bits.
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef CCFF_LOADER_CRC_EN
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CHAIN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LP_BYTE_W = CNT_W'(DATA_W);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_bits_left;
    logic              r_head_last;
    logic              r_done;

    logic              w_emit;
    logic              w_last_bit;
    logic              w_load_ready;
    logic              w_take_byte;
    logic              w_start;
    logic [CNT_W-1:0]  w_cnt_after;
    logic [3:0]        w_bits_new;

    assign w_emit       = (r_state == ST_LOAD) && (r_bits_left != 4'd0);
    assign w_last_bit   = w_emit && (r_cnt == CNT_W'(1));
    assign w_cnt_after  = w_emit ? (r_cnt - CNT_W'(1)) : r_cnt;
    // Look-ahead: the next byte may be taken on the edge that retires the current last bit.
    assign w_load_ready = (r_state == ST_LOAD) && (r_bits_left <= 4'd1) && (w_cnt_after != '0);
    assign w_take_byte  = s_valid && w_load_ready;
    assign w_start      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_bits_new   = (w_cnt_after >= LP_BYTE_W) ? 4'd8 : w_cnt_after[3:0];

    assign ccff_shift_en = w_emit;
    assign ccff_head     = w_emit ? r_shreg[DATA_W-1] : r_head_last;
    assign done          = r_done;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                s_ready = w_load_ready;
`ifdef CCFF_LOADER_CRC_EN
                if (w_last_bit) w_state_next = ST_CHECK;
`else
                if (w_last_bit) w_state_next = ST_DONE;
`endif
            end
`ifdef CCFF_LOADER_CRC_EN
            ST_CHECK: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) w_state_next = ST_DONE;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_bits_left <= 4'd0;
            r_head_last <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_start) begin
            r_cnt       <= LP_CHAIN;
            r_bits_left <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            if (w_emit) r_head_last <= r_shreg[DATA_W-1];
            if (w_take_byte) begin
                r_shreg     <= s_data;
                r_bits_left <= w_bits_new;
            end else if (w_emit) begin
                r_shreg     <= {r_shreg[DATA_W-2:0], 1'b0};
                r_bits_left <= r_bits_left - 4'd1;
            end
            r_cnt <= w_cnt_after;
`ifdef CCFF_LOADER_CRC_EN
            if ((r_state == ST_CHECK) && s_valid) r_done <= 1'b1;
`else
            if (w_last_bit) r_done <= 1'b1;
`endif
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    logic [7:0] r_crc;
    logic       r_error;

    // CRC-8, poly 0x07, init 0x00, MSB-first, over exactly the bits the chain captures.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_crc   <= 8'h00;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_crc   <= 8'h00;
            r_error <= 1'b0;
        end else begin
            if (w_emit) r_crc <= crc8_step(r_crc, r_shreg[DATA_W-1]);
            if ((r_state == ST_CHECK) && s_valid && (s_data != r_crc)) r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Randomised self-checking bench for ccff_stream_loader at chain lengths 16, 12 and 8.
// Compile with CCFF_LOADER_CRC_EN defined to exercise the CRC check byte.
module tb_ccff_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] valid_v = '0;
    logic [7:0] data_a [3];
    logic [2:0] ready_v, head_v, shen_v, busy_v, done_v, err_v;

    logic [7:0] tx_bytes [8];
    logic [7:0] tx_check;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    ccff_stream_loader #(.CHAIN_LEN(16)) u_l16 (
        .prog_clk(clk), .pReset(rst_n), .start(start_v[0]), .s_data(data_a[0]),
        .s_valid(valid_v[0]), .s_ready(ready_v[0]), .ccff_head(head_v[0]),
        .ccff_shift_en(shen_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]));

    ccff_stream_loader #(.CHAIN_LEN(12)) u_l12 (
        .prog_clk(clk), .pReset(rst_n), .start(start_v[1]), .s_data(data_a[1]),
        .s_valid(valid_v[1]), .s_ready(ready_v[1]), .ccff_head(head_v[1]),
        .ccff_shift_en(shen_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]));

    ccff_stream_loader #(.CHAIN_LEN(8)) u_l8 (
        .prog_clk(clk), .pReset(rst_n), .start(start_v[2]), .s_data(data_a[2]),
        .s_valid(valid_v[2]), .s_ready(ready_v[2]), .ccff_head(head_v[2]),
        .ccff_shift_en(shen_v[2]), .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic int chain_len(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 12 : 8);
    endfunction

    // Chain bit i is bit (7 - i%8) of byte i/8.
    function automatic logic model_bit(input int i);
        logic [7:0] b;
        b = tx_bytes[i / 8];
        return b[7 - (i % 8)];
    endfunction

    function automatic logic [7:0] model_crc(input int len);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < len; i++) begin
            if (c[7] ^ model_bit(i)) c = {c[6:0], 1'b0} ^ 8'h07;
            else                     c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic run_load(input int k, input int gap, input bit rnd_valid,
                            input bit start_while_busy, input int rst_after);
        int          len      = chain_len(k);
        int          nbytes   = (len + 7) / 8;
        int          sent     = 0;
        int          nbits    = 0;
        int          stalls   = 0;
        int          acc0     = -1;
        int          first_c  = -1;
        int          last_c   = -1;
        int          done_c   = -1;
        bit          in_gap;
        logic        last_bit = 1'b0;
        logic [63:0] got      = '0;
        logic [63:0] exp      = '0;

        @(posedge clk); #1;
        start_v[k] = 1'b1;
        valid_v[k] = 1'b0;
        @(posedge clk); #1;
        start_v[k] = 1'b0;

        for (int c = 1; c < 300 && done_c < 0; c++) begin
            in_gap     = (acc0 >= 0) && (c >= acc0 + 8) && (c < acc0 + 8 + gap);
            valid_v[k] = (sent <= nbytes) && !in_gap && (!rnd_valid || ($urandom_range(0, 2) != 0));
            data_a[k]  = (sent < nbytes) ? tx_bytes[sent] : tx_check;
            start_v[k] = start_while_busy && (c == 10);
            @(negedge clk);
            if (c == 1) check("start_state", {busy_v[k], done_v[k], err_v[k]}, 3'b100);
            if (shen_v[k]) begin
                got      = {got[62:0], head_v[k]};
                last_bit = head_v[k];
                nbits++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end else if (nbits > 0 && nbits < len) begin
                stalls++;
                check("stall_hold", head_v[k], last_bit);
            end
            if (ready_v[k] && valid_v[k]) begin
                if (sent == 0) acc0 = c;
                sent++;
            end
            if (rst_after > 0 && nbits == rst_after) begin
                #1 rst_n = 1'b0;
                #1 check("reset_outs", {ready_v[k], head_v[k], shen_v[k], busy_v[k], done_v[k], err_v[k]}, 6'b0);
                valid_v[k] = 1'b0;
                start_v[k] = 1'b0;
                return;
            end
            if (done_v[k]) done_c = c;
            else begin
                @(posedge clk); #1;
            end
        end
        start_v[k] = 1'b0;
        if (done_c < 0) check("timeout_done", 0, 1);

        for (int i = 0; i < len; i++) exp = {exp[62:0], model_bit(i)};
        check("bit_count", nbits, len);
        check("bit_stream", got, exp);
        check("busy_at_done", busy_v[k], 1'b0);
`ifdef CCFF_LOADER_CRC_EN
        check("bytes_taken", sent, nbytes + 1);
        check("crc_error", err_v[k], tx_check != model_crc(len));
`else
        check("bytes_taken", sent, nbytes);
        check("done_latency", done_c, last_c + 1);
        check("error_tied", err_v[k], 1'b0);
`endif
        if (gap > 0) check("gap_stalls", stalls, gap);
        else if (!rnd_valid) begin
            check("no_bubble", stalls, 0);
            check("first_latency", first_c, acc0 + 1);
        end

        // A byte offered after completion must not be consumed.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            valid_v[k] = 1'b1;
            @(negedge clk);
            check("ready_after_done", ready_v[k], 1'b0);
        end
        valid_v[k] = 1'b0;
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input int k);
        tx_bytes[0] = b0;
        tx_bytes[1] = b1;
        tx_check    = model_crc(chain_len(k));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data_a[i] = 8'h00;
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;
        tx_check = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("reset_state", {ready_v[k], head_v[k], shen_v[k], busy_v[k], done_v[k], err_v[k]}, 6'b0);
        rst_n = 1'b1;

        valid_v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("idle_no_ready", ready_v, 3'b000);
        end
        valid_v = 3'b000;

        set_bytes(8'hA5, 8'h3C, 0);
        run_load(0, 0, 1'b0, 1'b0, 0);
        set_bytes(8'hFF, 8'hF0, 1);
        run_load(1, 0, 1'b0, 1'b0, 0);
        set_bytes(8'($urandom), 8'($urandom), 0);
        run_load(0, 5, 1'b0, 1'b0, 0);

        set_bytes(8'hFF, 8'hFF, 0);
        run_load(0, 0, 1'b0, 1'b0, 5);
        @(negedge clk);
        rst_n = 1'b1;
        set_bytes(8'h5A, 8'hC3, 0);
        run_load(0, 0, 1'b0, 1'b0, 0);

        set_bytes(8'h01, 8'h00, 2);
        tx_check = 8'h07;
        run_load(2, 0, 1'b0, 1'b0, 0);
        tx_check = 8'h00;
        run_load(2, 0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            int k;
            k = int'($urandom_range(0, 2));
            set_bytes(8'($urandom), 8'($urandom), k);
            if ($urandom_range(0, 1) == 1) tx_check = tx_check ^ 8'($urandom_range(1, 255));
            run_load(k, 0, 1'b1, k == 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
